// File: rtl/axis_lite_s.sv
// AXI4-Lite slave exposing C_NUM_REGS x 32-bit registers, with app-side write/read strobes.
// Write and read channels run as independent two-state FSMs; every output comes straight from a flop.

module axis_lite_s #(
    parameter int                      C_ADDR_WIDTH = 32,
    parameter int                      C_NUM_REGS   = 16,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic [C_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    input  logic [C_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,

    output logic                    app_wen,
    output logic [7:0]              app_widx,
    output logic [31:0]             app_wdata,
    output logic                    app_ren,
    output logic [7:0]              app_ridx
);

    localparam int IDX_W = $clog2(C_NUM_REGS);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0]             regs [C_NUM_REGS];

    logic [0:0]              w_state;
    logic [0:0]              r_state;
    logic                    aw_held;
    logic                    w_held;
    logic [C_ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]             w_data_q;
    logic [3:0]              w_strb_q;

    logic                    aw_fire;
    logic                    w_fire;
    logic                    ar_fire;
    logic                    wr_go;
    logic [C_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]             wr_data;
    logic [3:0]              wr_strb;
    logic [C_ADDR_WIDTH-1:0] wr_off;
    logic                    wr_ok;
    logic [IDX_W-1:0]        wr_idx;
    logic [31:0]             wr_merged;
    logic [C_ADDR_WIDTH-1:0] rd_off;
    logic                    rd_ok;
    logic [IDX_W-1:0]        rd_idx;

    logic                    unused;
    assign unused = ^{s_axi_awprot, s_axi_arprot, wr_off[1:0], rd_off[1:0]};

    assign aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_fire  = s_axi_wvalid && s_axi_wready;
    assign ar_fire = s_axi_arvalid && s_axi_arready;

    // A half that is still arriving is taken straight from the bus so the write commits on its handshake edge.
    always_comb begin
        wr_addr   = aw_held ? aw_addr_q : s_axi_awaddr;
        wr_data   = w_held ? w_data_q : s_axi_wdata;
        wr_strb   = w_held ? w_strb_q : s_axi_wstrb;
        wr_go     = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
        wr_off    = wr_addr - C_BASE_ADDR;
        wr_ok     = (wr_addr >= C_BASE_ADDR) && (wr_off[C_ADDR_WIDTH-1:IDX_W+2] == '0);
        wr_idx    = wr_off[IDX_W+1:2];
        wr_merged = regs[wr_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_comb begin
        rd_off = s_axi_araddr - C_BASE_ADDR;
        rd_ok  = (s_axi_araddr >= C_BASE_ADDR) && (rd_off[C_ADDR_WIDTH-1:IDX_W+2] == '0);
        rd_idx = rd_off[IDX_W+1:2];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            app_wen       <= 1'b0;
            app_widx      <= '0;
            app_wdata     <= '0;
            // NOTE: the bank must read back as zero after reset, so it lives in flops with a reset loop, not in a RAM.
            for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
        end else begin
            app_wen <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (wr_go) begin
                        w_state       <= W_RESP;
                        aw_held       <= 1'b1;
                        w_held        <= 1'b1;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        s_axi_bvalid  <= 1'b1;
                        s_axi_bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        if (wr_ok) begin
                            regs[wr_idx] <= wr_merged;
                            app_wen      <= 1'b1;
                            app_widx     <= 8'(wr_idx);
                            app_wdata    <= wr_merged;
                        end
                    end else begin
                        if (aw_fire) begin
                            aw_held       <= 1'b1;
                            aw_addr_q     <= s_axi_awaddr;
                            s_axi_awready <= 1'b0;
                        end else begin
                            s_axi_awready <= !aw_held;
                        end
                        if (w_fire) begin
                            w_held       <= 1'b1;
                            w_data_q     <= s_axi_wdata;
                            w_strb_q     <= s_axi_wstrb;
                            s_axi_wready <= 1'b0;
                        end else begin
                            s_axi_wready <= !w_held;
                        end
                    end
                end
                default: begin
                    if (s_axi_bready) begin
                        w_state       <= W_IDLE;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: non-blocking updates mean rdata sees the bank as it was before a write committing on the same edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            app_ren       <= 1'b0;
            app_ridx      <= '0;
        end else begin
            app_ren <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_state       <= R_DATA;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rdata   <= rd_ok ? regs[rd_idx] : 32'h0;
                        s_axi_rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        if (rd_ok) begin
                            app_ren  <= 1'b1;
                            app_ridx <= 8'(rd_idx);
                        end
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                default: begin
                    if (s_axi_rready) begin
                        r_state       <= R_IDLE;
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_lite_s.sv
// Directed bench for axis_lite_s: handshakes, strobes, range errors, read-before-write and async reset.
module tb_axis_lite_s;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        app_wen;
    logic [7:0]  app_widx;
    logic [31:0] app_wdata;
    logic        app_ren;
    logic [7:0]  app_ridx;

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0;
    int ren_cnt = 0;

    axis_lite_s dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .app_wen       (app_wen),
        .app_widx      (app_widx),
        .app_wdata     (app_wdata),
        .app_ren       (app_ren),
        .app_ridx      (app_ridx)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (app_wen) wen_cnt <= wen_cnt + 1;
        if (app_ren) ren_cnt <= ren_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic wen, output logic [7:0] idx,
                             output logic [31:0] val);
        logic aw_f, w_f, done;
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            aw_f = s_axi_awvalid && s_axi_awready;
            w_f  = s_axi_wvalid && s_axi_wready;
            tick();
            if (aw_f) s_axi_awvalid = 1'b0;
            if (w_f)  s_axi_wvalid  = 1'b0;
            done = !s_axi_awvalid && !s_axi_wvalid;
        end
        check("wr_handshake", 32'(done), 32'd1);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("b_latency", 32'(s_axi_bvalid), 32'd1);
        resp = s_axi_bresp;
        wen  = app_wen;
        idx  = app_widx;
        val  = app_wdata;
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output logic ren, output logic [7:0] idx);
        logic ar_f, done;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            ar_f = s_axi_arvalid && s_axi_arready;
            tick();
            if (ar_f) begin
                s_axi_arvalid = 1'b0;
                done = 1'b1;
            end
        end
        check("rd_handshake", 32'(done), 32'd1);
        s_axi_arvalid = 1'b0;
        check("r_latency", 32'(s_axi_rvalid), 32'd1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        ren  = app_ren;
        idx  = app_ridx;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
    endtask

    logic [1:0]  resp;
    logic        en;
    logic [7:0]  idx;
    logic [31:0] val;
    int          wen_base, ren_base;

    initial begin
        // Reset and release
        #2 aresetn = 1'b0;
        #20;
        check("rst_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
        check("rst_valid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
        aresetn = 1'b1;
        tick();
        check("ready_after_rst", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

        // 1: AW and W together, then read back
        axi_write(32'h8, 32'h5AA5_A55A, 4'hF, resp, en, idx, val);
        check("s1_bresp", 32'(resp), 32'd0);
        check("s1_wen", 32'(en), 32'd1);
        check("s1_widx", 32'(idx), 32'd2);
        check("s1_wdata", val, 32'h5AA5_A55A);
        axi_read(32'h8, val, resp, en, idx);
        check("s1_rdata", val, 32'h5AA5_A55A);
        check("s1_rresp", 32'(resp), 32'd0);
        check("s1_ren", 32'(en), 32'd1);
        check("s1_ridx", 32'(idx), 32'd2);

        // 2: W three cycles ahead of AW, bready held low for 4 cycles
        s_axi_wdata  = 32'hCAFE_F00D;
        s_axi_wstrb  = 4'hF;
        s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        check("s2_wready_low", 32'(s_axi_wready), 32'd0);
        check("s2_b_early", 32'(s_axi_bvalid), 32'd0);
        tick();
        tick();
        check("s2_b_early2", 32'(s_axi_bvalid), 32'd0);
        check("s2_awready", 32'(s_axi_awready), 32'd1);
        s_axi_awaddr  = 32'h14;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("s2_bvalid", 32'(s_axi_bvalid), 32'd1);
        check("s2_bresp", 32'(s_axi_bresp), 32'd0);
        check("s2_wen", 32'(app_wen), 32'd1);
        check("s2_widx", 32'(app_widx), 32'd5);
        s_axi_awaddr  = 32'h20;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s2_b_hold", {29'd0, s_axi_bvalid, s_axi_bresp}, 32'h4);
            check("s2_no_aw", 32'(s_axi_awready), 32'd0);
        end
        s_axi_awvalid = 1'b0;
        s_axi_bready  = 1'b1;
        tick();
        s_axi_bready  = 1'b0;
        check("s2_b_done", 32'(s_axi_bvalid), 32'd0);
        check("s2_aw_back", 32'(s_axi_awready), 32'd1);
        axi_read(32'h14, val, resp, en, idx);
        check("s2_rdata", val, 32'hCAFE_F00D);
        axi_read(32'h20, val, resp, en, idx);
        check("s2_no_second", val, 32'h0);

        // 3: partial strobe
        axi_write(32'h8, 32'h1122_3344, 4'h5, resp, en, idx, val);
        check("s3_wdata", val, 32'h5A22_A544);
        axi_read(32'h8, val, resp, en, idx);
        check("s3_rdata", val, 32'h5A22_A544);

        // 4: out of range and index boundary
        wen_base = wen_cnt;
        ren_base = ren_cnt;
        axi_write(32'hAAAA_BBBB, 32'hDEAD_BEEF, 4'hF, resp, en, idx, val);
        check("s4_bresp", 32'(resp), 32'd2);
        check("s4_wen", 32'(en), 32'd0);
        axi_read(32'hAAAA_BBBB, val, resp, en, idx);
        check("s4_rresp", 32'(resp), 32'd2);
        check("s4_rdata", val, 32'h0);
        check("s4_ren", 32'(en), 32'd0);
        axi_read(32'h40, val, resp, en, idx);
        check("s4_edge_rresp", 32'(resp), 32'd2);
        check("s4_pulses", 32'(wen_cnt - wen_base) + 32'(ren_cnt - ren_base), 32'd0);
        axi_read(32'h8, val, resp, en, idx);
        check("s4_reg2_kept", val, 32'h5A22_A544);
        axi_read(32'h14, val, resp, en, idx);
        check("s4_reg5_kept", val, 32'hCAFE_F00D);
        axi_write(32'h3F, 32'h0F0F_0F0F, 4'hF, resp, en, idx, val);
        check("s4_last_bresp", 32'(resp), 32'd0);
        check("s4_last_widx", 32'(idx), 32'd15);

        // 5: read and write to the same register on the same edge
        axi_write(32'hC, 32'h1, 4'hF, resp, en, idx, val);
        s_axi_awaddr  = 32'hC;
        s_axi_wdata   = 32'h2;
        s_axi_wstrb   = 4'hF;
        s_axi_araddr  = 32'hC;
        check("s5_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        check("s5_valids", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd3);
        check("s5_old_rdata", s_axi_rdata, 32'h1);
        check("s5_pulses", {30'd0, app_wen, app_ren}, 32'd3);
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        axi_read(32'hC, val, resp, en, idx);
        check("s5_new_rdata", val, 32'h2);

        // 6: reset while both responses are pending
        s_axi_awaddr  = 32'hAAAA_BBBB;
        s_axi_wdata   = 32'h1234_5678;
        s_axi_araddr  = 32'h14;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        check("s6_pending", {28'd0, s_axi_bvalid, s_axi_rvalid, s_axi_bresp}, 32'hE);
        check("s6_rdata_pre", s_axi_rdata, 32'hCAFE_F00D);
        #2 aresetn = 1'b0;
        #1;
        check("s6_ctrl_zero", {23'd0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                               s_axi_rvalid, app_wen, app_ren, s_axi_bresp == 2'b00, s_axi_rresp == 2'b00},
              32'h3);
        check("s6_rdata_zero", s_axi_rdata, 32'h0);
        check("s6_wdata_zero", app_wdata, 32'h0);
        check("s6_idx_zero", {16'd0, app_widx, app_ridx}, 32'h0);
        tick();
        aresetn = 1'b1;
        tick();
        check("s6_ready_back", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
        check("s6_no_resp", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
        axi_read(32'h8, val, resp, en, idx);
        check("s6_reg_cleared", val, 32'h0);
        check("s6_rresp", 32'(resp), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
